// File: rtl/input_conditioner.sv
// Two-player input conditioner: 2-flop sync, per-bit debounce, registered active-low outputs
// and a VBLK-counted coin stretch. Optional macro SOCD_CLEAN_EN releases opposing directions.
module input_conditioner #(
    parameter int DEB_CYCLES  = 24000,
    parameter int COIN_FRAMES = 4
) (
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic       VBLK,
    input  logic [7:0] raw_p1,
    input  logic [7:0] raw_p2,
    output logic [7:0] ctr1_n,
    output logic [7:0] ctr2_n,
    output logic [1:0] coin_busy
);
    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} coin_state_e;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [3:0]  FRAMES   = 4'(COIN_FRAMES);

    // Player 2 occupies the upper byte of every 16-bit vector.
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;
    logic [2:0]  vblk_q;
    logic        vblk_rise;

    logic [15:0] stable_q;
    logic [15:0] stable_d;
    logic [15:0] cnt_q [16];
    logic [15:0] cnt_d [16];
    logic [13:0] btn_n_q;
    logic [13:0] btn_n_d;

    coin_state_e state_q  [2];
    logic [3:0]  frames_q [2];
    logic [1:0]  coin_n_q;
    logic [1:0]  busy_q;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vblk_q  <= '0;
        end else begin
            sync1_q <= {raw_p2, raw_p1};
            sync2_q <= sync1_q;
            vblk_q  <= {vblk_q[1:0], VBLK};
        end
    end

    assign vblk_rise = vblk_q[1] & ~vblk_q[2];

    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < 16; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == DEB_LAST) begin
                    stable_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 16'd1;
                end
            end
        end
    end

    function automatic logic [6:0] clean_dirs(input logic [6:0] s);
        logic [6:0] r;
        r = s;
`ifdef SOCD_CLEAN_EN
        if (s[5] && s[4]) r[5:4] = 2'b00;
        if (s[3] && s[2]) r[3:2] = 2'b00;
`endif
        return r;
    endfunction

    always_comb begin
        btn_n_d = {~clean_dirs(stable_q[14:8]), ~clean_dirs(stable_q[6:0])};
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            stable_q <= '0;
            btn_n_q  <= '1;
            for (int b = 0; b < 16; b++) cnt_q[b] <= '0;
        end else begin
            stable_q <= stable_d;
            btn_n_q  <= btn_n_d;
            for (int b = 0; b < 16; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    // IDLE is only re-entered with the debounced coin low, so a high level there is a fresh press.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]  <= IDLE;
                frames_q[p] <= '0;
            end
            coin_n_q <= 2'b11;
            busy_q   <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                case (state_q[p])
                    IDLE: begin
                        if (stable_q[8*p+7]) begin
                            state_q[p]  <= HOLD;
                            frames_q[p] <= '0;
                            coin_n_q[p] <= 1'b0;
                            busy_q[p]   <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (vblk_rise) begin
                            frames_q[p] <= frames_q[p] + 4'd1;
                            if (frames_q[p] + 4'd1 == FRAMES) begin
                                state_q[p]  <= RELEASE;
                                coin_n_q[p] <= 1'b1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (!stable_q[8*p+7]) begin
                            state_q[p] <= IDLE;
                            busy_q[p]  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[p]  <= IDLE;
                        coin_n_q[p] <= 1'b1;
                        busy_q[p]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctr1_n    = {coin_n_q[0], btn_n_q[6:0]};
    assign ctr2_n    = {coin_n_q[1], btn_n_q[13:7]};
    assign coin_busy = busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEB_CYCLES=4, COIN_FRAMES=4); honours SOCD_CLEAN_EN.
module tb_input_conditioner;
    localparam int DEB = 4;
    localparam int CF  = 4;
    localparam int VP  = 20;
    localparam int HD  = DEB + 2;
`ifdef SOCD_CLEAN_EN
    localparam logic [1:0] SOCD_BOTH = 2'b11;
`else
    localparam logic [1:0] SOCD_BOTH = 2'b00;
`endif

    logic       clk_sys;
    logic       RESET;
    logic       VBLK;
    logic [7:0] raw_p1;
    logic [7:0] raw_p2;
    logic [7:0] ctr1_n;
    logic [7:0] ctr2_n;
    logic [1:0] coin_busy;

    int checks = 0;
    int passes = 0;

    input_conditioner #(.DEB_CYCLES(DEB), .COIN_FRAMES(CF)) dut (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .VBLK     (VBLK),
        .raw_p1   (raw_p1),
        .raw_p2   (raw_p2),
        .ctr1_n   (ctr1_n),
        .ctr2_n   (ctr2_n),
        .coin_busy(coin_busy)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        int vcnt;
        vcnt = 0;
        VBLK = 1'b0;
        forever begin
            @(negedge clk_sys);
            vcnt = (vcnt == VP - 1) ? 0 : vcnt + 1;
            VBLK = (vcnt < 4);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2);
        @(negedge clk_sys);
        raw_p1 = p1;
        raw_p2 = p2;
    endtask

    // Behavioural model: a level is accepted once DEB consecutive synchronised samples disagree with it.
    logic [15:0] m_hist [HD];
    logic [3:0]  m_vhist;
    logic [15:0] m_acc;
    logic [1:0]  m_armed;
    logic [1:0]  m_on;
    int          m_left [2];
    logic [7:0]  m_ctr1_n;
    logic [7:0]  m_ctr2_n;
    logic [1:0]  m_busy;
    bit          model_valid = 0;

    function automatic logic [6:0] cleanDirs(input logic [6:0] s);
        logic [6:0] r;
        r = s;
`ifdef SOCD_CLEAN_EN
        if (s[5] && s[4]) r[5:4] = 2'b00;
        if (s[3] && s[2]) r[3:2] = 2'b00;
`endif
        return r;
    endfunction

    initial begin
        bit vrise;
        bit all_diff;
        forever begin
            @(posedge clk_sys);
            if (RESET) begin
                for (int i = 0; i < HD; i++) m_hist[i] = '0;
                m_vhist  = '0;
                m_acc    = '0;
                m_armed  = 2'b11;
                m_on     = 2'b00;
                m_left[0] = 0;
                m_left[1] = 0;
                m_ctr1_n = 8'hFF;
                m_ctr2_n = 8'hFF;
                m_busy   = 2'b00;
                model_valid = 1;
            end else begin
                for (int i = HD - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = {raw_p2, raw_p1};
                m_vhist   = {m_vhist[2:0], VBLK};
                m_ctr1_n[6:0] = ~cleanDirs(m_acc[6:0]);
                m_ctr2_n[6:0] = ~cleanDirs(m_acc[14:8]);
                vrise = m_vhist[2] && !m_vhist[3];
                for (int p = 0; p < 2; p++) begin
                    if (m_armed[p]) begin
                        if (m_acc[8*p+7]) begin
                            m_armed[p] = 1'b0;
                            m_on[p]    = 1'b1;
                            m_left[p]  = CF;
                        end
                    end else if (m_on[p]) begin
                        if (vrise) begin
                            m_left[p] = m_left[p] - 1;
                            if (m_left[p] == 0) m_on[p] = 1'b0;
                        end
                    end else if (!m_acc[8*p+7]) begin
                        m_armed[p] = 1'b1;
                    end
                end
                m_ctr1_n[7] = ~m_on[0];
                m_ctr2_n[7] = ~m_on[1];
                m_busy      = ~m_armed;
                for (int b = 0; b < 16; b++) begin
                    all_diff = 1;
                    for (int i = 2; i <= DEB + 1; i++)
                        if (m_hist[i][b] == m_acc[b]) all_diff = 0;
                    if (all_diff) m_acc[b] = ~m_acc[b];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (model_valid) begin
                checkOutput("cycle_ctr1_n", ctr1_n, m_ctr1_n);
                checkOutput("cycle_ctr2_n", ctr2_n, m_ctr2_n);
                checkOutput("cycle_coin_busy", coin_busy, m_busy);
            end
        end
    end

    // Completed player-1 coin pulses and the width of the most recent one, in cycles.
    int pulses = 0;
    int low_run = 0;
    int last_width = 0;
    initial begin
        forever begin
            @(negedge clk_sys);
            if (ctr1_n[7] === 1'b0) begin
                low_run++;
            end else if (low_run > 0) begin
                last_width = low_run;
                pulses++;
                low_run = 0;
            end
        end
    end

    task automatic waitCoinLow(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (ctr1_n[7] === 1'b0) break;
            @(negedge clk_sys);
        end
        checkOutput("coin_assert", ctr1_n[7], 1'b0);
    endtask

    function automatic logic widthOk(input int w);
        return (w > 3 * VP) && (w <= 4 * VP);
    endfunction

    initial begin
        logic [7:0] and_acc;
        int edges;
        RESET  = 1'b1;
        raw_p1 = '0;
        raw_p2 = '0;
        repeat (3) @(negedge clk_sys);
        checkOutput("reset_ctr1_n", ctr1_n, 8'hFF);
        checkOutput("reset_ctr2_n", ctr2_n, 8'hFF);
        checkOutput("reset_coin_busy", coin_busy, 2'b00);
        RESET = 1'b0;
        repeat (5) @(negedge clk_sys);

        applyStimulus(8'h02, 8'h00);
        repeat (6) @(negedge clk_sys);
        checkOutput("deb_edge6", ctr1_n, 8'hFF);
        @(negedge clk_sys);
        checkOutput("deb_edge7", ctr1_n, 8'hFD);
        checkOutput("deb_p2_quiet", ctr2_n, 8'hFF);
        applyStimulus(8'h00, 8'h00);
        repeat (12) @(negedge clk_sys);
        checkOutput("deb_release", ctr1_n, 8'hFF);

        applyStimulus(8'h00, 8'h20);
        repeat (2) @(negedge clk_sys);
        applyStimulus(8'h00, 8'h00);
        and_acc = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            and_acc &= ctr2_n;
        end
        checkOutput("glitch_ctr2_n", and_acc, 8'hFF);

        pulses = 0;
        applyStimulus(8'h80, 8'h01);
        repeat (100 * VP) @(negedge clk_sys);
        checkOutput("coin_single_pulse", pulses, 1);
        checkOutput("coin_width", widthOk(last_width), 1'b1);
        checkOutput("coin_busy_held", coin_busy[0], 1'b1);
        applyStimulus(8'h00, 8'h00);
        repeat (20) @(negedge clk_sys);
        checkOutput("coin_busy_clear", coin_busy, 2'b00);

        pulses = 0;
        applyStimulus(8'h80, 8'h00);
        waitCoinLow(60);
        repeat (25) @(negedge clk_sys);
        applyStimulus(8'h00, 8'h00);
        repeat (10) @(negedge clk_sys);
        applyStimulus(8'h80, 8'h00);
        repeat (100) @(negedge clk_sys);
        checkOutput("repress_one_pulse", pulses, 1);
        checkOutput("repress_width", widthOk(last_width), 1'b1);
        applyStimulus(8'h00, 8'h00);
        repeat (20) @(negedge clk_sys);
        checkOutput("repress_idle", coin_busy[0], 1'b0);
        applyStimulus(8'h80, 8'h00);
        waitCoinLow(60);
        repeat (100) @(negedge clk_sys);
        checkOutput("repress_new_pulse", pulses, 2);
        checkOutput("repress_new_width", widthOk(last_width), 1'b1);
        applyStimulus(8'h00, 8'h00);
        repeat (20) @(negedge clk_sys);

        applyStimulus(8'h80, 8'h00);
        waitCoinLow(60);
        repeat (25) @(negedge clk_sys);
        RESET = 1'b1;
        @(negedge clk_sys);
        RESET = 1'b0;
        checkOutput("rst_hold_ctr1_n", ctr1_n, 8'hFF);
        checkOutput("rst_hold_busy", coin_busy, 2'b00);
        edges = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            edges++;
            if (ctr1_n[7] === 1'b0) break;
        end
        checkOutput("rst_reassert_edge", edges, 7);
        applyStimulus(8'h00, 8'h00);
        repeat (100) @(negedge clk_sys);

        applyStimulus(8'h30, 8'h0C);
        repeat (12) @(negedge clk_sys);
        checkOutput("socd_updown", ctr1_n[5:4], SOCD_BOTH);
        checkOutput("socd_leftright", ctr2_n[3:2], SOCD_BOTH);
        applyStimulus(8'h10, 8'h0C);
        repeat (6) @(negedge clk_sys);
        checkOutput("socd_edge6", ctr1_n[5:4], SOCD_BOTH);
        @(negedge clk_sys);
        checkOutput("socd_edge7", ctr1_n[5:4], 2'b10);
        applyStimulus(8'h00, 8'h00);
        repeat (12) @(negedge clk_sys);
        checkOutput("final_idle", {ctr2_n, ctr1_n}, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish (passed %0d of %0d)", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
